// File: rtl/freq_word_calc.sv
// ---------------------------------------------------------------------------
// freq_word_calc
// Converts a four-digit BCD keypad entry (Hz or kHz) into a binary frequency
// and the matching 32-bit NCO tuning word, using a sequential BCD-to-binary
// pass, an optional x1000 scale, and a 30-cycle shift-add multiply by TW_MULT.
//
// Ports
//   clk_1MHz   in   sole clock, rising edge
//   rst        in   asynchronous, active-high reset
//   start      in   conversion request, accepted only when idle
//   value_in   in   [15:12] thousands .. [3:0] units, BCD
//   Msel       in   0 = Hz, 1 = kHz
//   busy       out  conversion in progress
//   done       out  one-cycle completion pulse
//   err        out  last accepted request contained a non-BCD digit
//   frequency  out  binary frequency in Hz
//   phase_inc  out  NCO tuning word, bits [47:16] of acc * TW_MULT
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for start; latches value_in/Msel on acceptance
//   S_BCD   | 4 cycles, MSD first: acc = acc*10 + digit (or error exit)
//   S_SCALE | 1 cycle: acc *= 1000 when Msel was set
//   S_MUL   | 30 cycles: product += TW_MULT << i when acc bit i is set
//   S_DONE  | register results, pulse done, return to idle
// ---------------------------------------------------------------------------
module freq_word_calc #(
    parameter logic [22:0] TW_MULT = 23'd5629500
) (
    input  logic        clk_1MHz,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] value_in,
    input  logic        Msel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [29:0] frequency,
    output logic [31:0] phase_inc
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BCD   = 3'd1;
    localparam logic [2:0] S_SCALE = 3'd2;
    localparam logic [2:0] S_MUL   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  r_state;
    logic [4:0]  r_cnt;
    logic [15:0] r_val;
    logic        r_msel;
    logic [29:0] r_acc;
    logic [29:0] r_mplier;
    logic [52:0] r_mcand;
    logic [52:0] r_prod;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [29:0] r_freq;
    logic [31:0] r_phase;

    logic [3:0]  w_digit;
    logic        w_bad;
    logic [29:0] w_acc_next;
    logic [29:0] w_scaled;

    // The BCD down-counter runs 3..0, so count 3 selects the thousands digit.
    always_comb begin
        w_digit = 4'd0;
        case (r_cnt[1:0])
            2'd3:    w_digit = r_val[15:12];
            2'd2:    w_digit = r_val[11:8];
            2'd1:    w_digit = r_val[7:4];
            default: w_digit = r_val[3:0];
        endcase
    end

    assign w_bad = (r_val[15:12] > 4'd9) || (r_val[11:8] > 4'd9) ||
                   (r_val[7:4]   > 4'd9) || (r_val[3:0]  > 4'd9);

    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {26'd0, w_digit};

    // x1000 as 1024 - 16 - 8
    assign w_scaled = r_msel ? ((r_acc << 10) - (r_acc << 4) - (r_acc << 3)) : r_acc;

    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_val    <= 16'd0;
            r_msel   <= 1'b0;
            r_acc    <= 30'd0;
            r_mplier <= 30'd0;
            r_mcand  <= 53'd0;
            r_prod   <= 53'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_freq   <= 30'd0;
            r_phase  <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_val   <= value_in;
                        r_msel  <= Msel;
                        r_acc   <= 30'd0;
                        r_prod  <= 53'd0;
                        r_cnt   <= 5'd3;
                        r_state <= S_BCD;
                    end
                end
                S_BCD: begin
                    // The digit check happens on the first BCD cycle, before
                    // busy is raised, so a rejected entry never shows busy.
                    if (w_bad) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_busy <= 1'b1;
                        r_acc  <= w_acc_next;
                        if (r_cnt == 5'd0) begin
                            r_state <= S_SCALE;
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                end
                S_SCALE: begin
                    r_acc    <= w_scaled;
                    r_mplier <= w_scaled;
                    r_mcand  <= {30'd0, TW_MULT};
                    r_cnt    <= 5'd29;
                    r_state  <= S_MUL;
                end
                S_MUL: begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == 5'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_DONE: begin
                    r_freq  <= r_acc;
                    r_phase <= r_prod[47:16];
                    r_err   <= 1'b0;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign frequency = r_freq;
    assign phase_inc = r_phase;

endmodule

// File: tb/tb_freq_word_calc.sv
module tb_freq_word_calc;

    logic        clk_1MHz = 1'b0;
    logic        rst      = 1'b1;
    logic        start    = 1'b0;
    logic [15:0] value_in = 16'd0;
    logic        Msel     = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [29:0] frequency;
    logic [31:0] phase_inc;

    freq_word_calc dut (
        .clk_1MHz  (clk_1MHz),
        .rst       (rst),
        .start     (start),
        .value_in  (value_in),
        .Msel      (Msel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .frequency (frequency),
        .phase_inc (phase_inc)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    typedef struct {
        logic [29:0] f;
        logic [31:0] p;
        logic        e;
        int unsigned at;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned edge_cnt = 0;
    logic [29:0] last_f = 30'd0;
    logic [31:0] last_p = 32'd0;
    logic        prev_done = 1'b0;
    exp_t        mon_e;

    always @(posedge clk_1MHz) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk_1MHz) begin
        if (done) begin
            chk("done_width", {63'd0, prev_done}, 64'd0);
            chk("busy_in_done", {63'd0, busy}, 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("frequency", {34'd0, frequency}, {34'd0, mon_e.f});
                chk("phase_inc", {32'd0, phase_inc}, {32'd0, mon_e.p});
                chk("err", {63'd0, err}, {63'd0, mon_e.e});
                chk("latency_edge", {32'd0, edge_cnt}, {32'd0, mon_e.at});
            end
        end
        prev_done = done;
    end

    // Called at a negedge; start is then sampled on the next edge (k).
    task automatic push_exp(input logic [29:0] f, input logic [31:0] p, input logic e, input int unsigned lat);
        exp_t x;
        x.f  = f;
        x.p  = p;
        x.e  = e;
        x.at = edge_cnt + 1 + lat;
        sb.push_back(x);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk_1MHz);
        chk("drain_timeout", {32'd0, sb.size()}, 64'd0);
        sb.delete();
        @(negedge clk_1MHz);
    endtask

    task automatic conv(input logic [15:0] v, input logic m, input logic [29:0] f, input logic [31:0] p);
        @(negedge clk_1MHz);
        value_in = v;
        Msel     = m;
        start    = 1'b1;
        push_exp(f, p, 1'b0, 36);
        last_f = f;
        last_p = p;
        @(negedge clk_1MHz);
        start    = 1'b0;
        value_in = 16'h8888;
        Msel     = ~m;
        @(negedge clk_1MHz);
        chk("busy_after_k1", {63'd0, busy}, 64'd1);
        wait_drain();
    endtask

    task automatic err_conv(input logic [15:0] v, input logic m);
        @(negedge clk_1MHz);
        value_in = v;
        Msel     = m;
        start    = 1'b1;
        push_exp(last_f, last_p, 1'b1, 1);
        @(negedge clk_1MHz);
        start = 1'b0;
        chk("err_busy_k", {63'd0, busy}, 64'd0);
        @(negedge clk_1MHz);
        chk("err_busy_k1", {63'd0, busy}, 64'd0);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k0;

        @(negedge clk_1MHz);
        @(negedge clk_1MHz);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_freq", {34'd0, frequency}, 64'd0);
        chk("rst_phase", {32'd0, phase_inc}, 64'd0);
        #2 rst = 1'b0;

        conv(16'h1234, 1'b0, 30'd1234, 32'd105999);
        conv(16'h9999, 1'b1, 30'd9999000, 32'd858907630);
        err_conv(16'h12A4, 1'b0);
        conv(16'h0001, 1'b0, 30'd1, 32'd85);
        err_conv(16'hF000, 1'b1);
        conv(16'h0010, 1'b0, 30'd10, 32'd858);

        // start held high; inputs change while busy and during the done cycle
        @(negedge clk_1MHz);
        value_in = 16'h0001;
        Msel     = 1'b1;
        start    = 1'b1;
        push_exp(30'd1000, 32'd85899, 1'b0, 36);
        k0 = edge_cnt + 1;
        @(negedge clk_1MHz);
        value_in = 16'h9999;
        Msel     = 1'b1;
        for (int i = 0; i < 100 && edge_cnt < k0 + 36; i++) @(negedge clk_1MHz);
        value_in = 16'h0010;
        Msel     = 1'b0;
        push_exp(30'd10, 32'd858, 1'b0, 36);
        chk("held_second_accept_edge", {32'd0, edge_cnt + 1}, {32'd0, k0 + 37});
        @(negedge clk_1MHz);
        value_in = 16'h9999;
        Msel     = 1'b1;
        start    = 1'b0;
        last_f   = 30'd10;
        last_p   = 32'd858;
        wait_drain();

        // reset during MUL
        err_conv(16'h000A, 1'b1);
        @(negedge clk_1MHz);
        value_in = 16'h1234;
        Msel     = 1'b0;
        start    = 1'b1;
        @(negedge clk_1MHz);
        start = 1'b0;
        repeat (15) @(negedge clk_1MHz);
        chk("busy_before_rst", {63'd0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_err", {63'd0, err}, 64'd0);
        chk("arst_freq", {34'd0, frequency}, 64'd0);
        chk("arst_phase", {32'd0, phase_inc}, 64'd0);
        @(negedge clk_1MHz);
        @(negedge clk_1MHz);
        value_in = 16'h0000;
        Msel     = 1'b0;
        start    = 1'b1;
        push_exp(30'd0, 32'd0, 1'b0, 36);
        #2 rst = 1'b0;
        @(negedge clk_1MHz);
        start = 1'b0;
        last_f = 30'd0;
        last_p = 32'd0;
        wait_drain();

        conv(16'h0001, 1'b1, 30'd1000, 32'd85899);
        err_conv(16'h0B00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
